seq_alu: RTL and testbench

//   Datapath ALU sitting directly upstream of the flags register. Executes one op per

---
 rtl/seq_alu_if.sv | 34 +++
 rtl/seq_alu.sv | 148 ++++++++++++++
 tb/tb_seq_alu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Request/response bundle between a requester and seq_alu.
//                The requester drives start/op/a/b. The ALU returns busy,
//                done, result, the z/p flags and the flags-register write
//                enable.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             z_out;
    logic             p_out;
    logic             flag_write_enable;

    modport master (
        output start, op, a, b,
        input  busy, done, result, z_out, p_out, flag_write_enable
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, z_out, p_out, flag_write_enable
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU feeding the flags register. Logic and
//                arithmetic ops complete in one cycle. MUL is a WIDTH-cycle
//                shift-add multiplier. The result and the zero/parity flags
//                are registered together, and done pulses once per accepted
//                request.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seq_alu_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0]       C_OP_ADD   = 3'b000;
    localparam logic [2:0]       C_OP_SUB   = 3'b001;
    localparam logic [2:0]       C_OP_AND   = 3'b010;
    localparam logic [2:0]       C_OP_OR    = 3'b011;
    localparam logic [2:0]       C_OP_XOR   = 3'b100;
    localparam logic [2:0]       C_OP_SHL   = 3'b101;
    localparam logic [2:0]       C_OP_SHR   = 3'b110;
    localparam logic [2:0]       C_OP_MUL   = 3'b111;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q,      z_d;
    logic             p_q,      p_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_sum;

    // Single-cycle ops decoded straight from the request operands.
    always_comb begin
        alu_res = '0;
        case (bus.op)
            C_OP_ADD: alu_res = bus.a + bus.b;
            C_OP_SUB: alu_res = bus.a - bus.b;
            C_OP_AND: alu_res = bus.a & bus.b;
            C_OP_OR:  alu_res = bus.a | bus.b;
            C_OP_XOR: alu_res = bus.a ^ bus.b;
            C_OP_SHL: alu_res = {bus.a[WIDTH-2:0], 1'b0};
            C_OP_SHR: alu_res = {1'b0, bus.a[WIDTH-1:1]};
            default:  alu_res = '0;  // MUL takes the iterative path
        endcase
    end

    // One shift-add step; the final step's sum is the product itself.
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state logic. Flags are always derived from the value being
    // written into result, never from the operands.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        z_d      = z_q;
        p_d      = p_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == C_OP_MUL) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        z_d      = (alu_res == '0);
                        p_d      = ~^alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + C_CNT_ONE;
                if (count_q == C_CNT_LAST) begin
                    result_d = acc_sum;
                    z_d      = (acc_sum == '0);
                    p_d      = ~^acc_sum;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any MUL in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            p_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            z_q      <= z_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy              = (state_q == ST_MUL);
    assign bus.done              = done_q;
    assign bus.flag_write_enable = done_q;
    assign bus.result            = result_q;
    assign bus.z_out             = z_q;
    assign bus.p_out             = p_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (WIDTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt;

    seq_alu_if #(.WIDTH(WIDTH)) bus_if ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
    endtask

    task automatic idle();
        bus_if.start = 1'b0;
        bus_if.op    = 3'b000;
        bus_if.a     = 8'h00;
        bus_if.b     = 8'h00;
    endtask

    task automatic chk_out(input string tag, input logic d, input logic [7:0] r,
                           input logic z, input logic p);
        chk({tag, "_done"}, 32'(bus_if.done), 32'(d));
        chk({tag, "_fwe"},  32'(bus_if.flag_write_enable), 32'(d));
        chk({tag, "_res"},  32'(bus_if.result), 32'(r));
        chk({tag, "_z"},    32'(bus_if.z_out), 32'(z));
        chk({tag, "_p"},    32'(bus_if.p_out), 32'(p));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset_busy", 32'(bus_if.busy), 32'd0);
        rst = 1'b0;

        // ADD 0x80+0x80 wraps to zero
        req(3'b000, 8'h80, 8'h80);
        tick();
        idle();
        chk_out("add", 1'b1, 8'h00, 1'b1, 1'b1);
        tick();
        chk_out("add_after", 1'b0, 8'h00, 1'b1, 1'b1);

        // SUB, SHR, SHL
        req(3'b001, 8'h05, 8'h03);
        tick();
        idle();
        chk_out("sub", 1'b1, 8'h02, 1'b0, 1'b0);
        req(3'b110, 8'h81, 8'hFF);
        tick();
        chk_out("shr", 1'b1, 8'h40, 1'b0, 1'b0);
        req(3'b101, 8'h81, 8'h55);
        tick();
        idle();
        chk_out("shl", 1'b1, 8'h02, 1'b0, 1'b0);

        // MUL 7*9 with an ADD request arriving mid-iteration
        req(3'b111, 8'h07, 8'h09);
        tick();
        idle();
        chk("mul_busy_e0", 32'(bus_if.busy), 32'd1);
        done_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3 || k == 4) req(3'b000, 8'h01, 8'h01);
            else idle();
            tick();
            if (bus_if.done) done_cnt++;
            if (k < 8) begin
                chk($sformatf("mul_busy_%0d", k), 32'(bus_if.busy), 32'd1);
                chk($sformatf("mul_hold_%0d", k), 32'(bus_if.result), 32'h02);
            end
        end
        idle();
        chk_out("mul7x9", 1'b1, 8'h3F, 1'b0, 1'b1);
        chk("mul7x9_busy", 32'(bus_if.busy), 32'd0);
        tick();
        if (bus_if.done) done_cnt++;
        chk("mul7x9_one_done", 32'(done_cnt), 32'd1);
        chk_out("mul7x9_after", 1'b0, 8'h3F, 1'b0, 1'b1);

        // MUL 16*16 -> low byte zero
        req(3'b111, 8'h10, 8'h10);
        tick();
        idle();
        for (int k = 1; k < 8; k++) tick();
        chk("mul16_pre_done", 32'(bus_if.done), 32'd0);
        tick();
        chk_out("mul16x16", 1'b1, 8'h00, 1'b1, 1'b1);

        // MUL 0xFF*0xFF = 0xFE01 -> low byte 0x01
        req(3'b111, 8'hFF, 8'hFF);
        tick();
        idle();
        for (int k = 1; k <= 8; k++) tick();
        chk_out("mulff", 1'b1, 8'h01, 1'b0, 1'b0);

        // Reset during the 4th MUL cycle discards the operation
        req(3'b111, 8'h07, 8'h09);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("rstmul_busy_pre", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rstmul", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rstmul_busy", 32'(bus_if.busy), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus_if.done) done_cnt++;
        end
        chk("rstmul_no_done", 32'(done_cnt), 32'd0);

        // Start held for three back-to-back single-cycle ops
        req(3'b100, 8'hF0, 8'h0F);
        tick();
        chk_out("b2b_xor", 1'b1, 8'hFF, 1'b0, 1'b1);
        req(3'b010, 8'hF0, 8'h0F);
        tick();
        chk_out("b2b_and", 1'b1, 8'h00, 1'b1, 1'b1);
        req(3'b011, 8'h01, 8'h02);
        tick();
        idle();
        chk_out("b2b_or", 1'b1, 8'h03, 1'b0, 1'b1);
        tick();
        chk_out("b2b_after", 1'b0, 8'h03, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
